// File: rtl/cg_pkg.sv
// Shared types and constants for the clock-enable controller and its per-domain FSMs.
package cg_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2
    } cg_state_t;

    localparam int NUM_CG_DOMAINS = 3;

    localparam int CG_CONV = 0;
    localparam int CG_POOL = 1;
    localparam int CG_FC   = 2;

    // Counter widths cover the legal parameter ranges (wake 1..15, idle 1..255).
    localparam int WAKE_CNT_W = 4;
    localparam int IDLE_CNT_W = 8;

endpackage

// File: rtl/cg_domain_fsm.sv
// One clock domain's OFF/WAKE/ON sequencer with wake/idle counters, sticky busy-misuse flag
// and, when CG_STATS_EN is defined, a saturating enabled-cycle counter.
module cg_domain_fsm
    import cg_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8
`ifdef CG_STATS_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_busy,
    input  logic             i_force,
`ifdef CG_STATS_EN
    input  logic             i_clr_stats,
    output logic [CNT_W-1:0] o_cyc,
`endif
    output logic             o_en,
    output logic             o_rdy,
    output logic             o_err,
    output logic [1:0]       o_state
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_CYCLES - 1);

    cg_state_t             r_state;
    logic [WAKE_CNT_W-1:0] r_wake;
    logic [IDLE_CNT_W-1:0] r_idle;
    logic                  r_en;
    logic                  r_rdy;
    logic                  r_err;
    logic                  w_active;

    assign w_active = i_req | i_busy | i_force;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CG_OFF;
            r_wake  <= '0;
            r_idle  <= '0;
            r_en    <= 1'b0;
            r_rdy   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // An engine claiming busy before its clock is confirmed running is a protocol fault.
            if (i_busy && (r_state != CG_ON)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                CG_OFF: begin
                    if (w_active) begin
                        r_state <= CG_WAKE;
                        r_en    <= 1'b1;
                        r_wake  <= WAKE_LOAD;
                    end
                end
                CG_WAKE: begin
                    if (r_wake == '0) begin
                        r_state <= CG_ON;
                        r_rdy   <= 1'b1;
                        r_idle  <= '0;
                    end else begin
                        r_wake <= r_wake - 1'b1;
                    end
                end
                CG_ON: begin
                    // An active cycle beats an expiring idle count, so there is no enable glitch.
                    if (w_active) begin
                        r_idle <= '0;
                    end else if (r_idle == IDLE_LAST) begin
                        r_state <= CG_OFF;
                        r_en    <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_idle  <= '0;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                default: begin
                    r_state <= CG_OFF;
                    r_en    <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_en    = r_en;
    assign o_rdy   = r_rdy;
    assign o_err   = r_err;
    assign o_state = r_state;

`ifdef CG_STATS_EN
    logic [CNT_W-1:0] r_cyc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc <= '0;
        end else if (i_clr_stats) begin
            r_cyc <= '0;
        end else if (r_en && (r_cyc != {CNT_W{1'b1}})) begin
            r_cyc <= r_cyc + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cyc = r_cyc;
`endif

endmodule

// File: rtl/clock_enable_controller.sv
// Per-engine clock-enable generator feeding the clock-gating unit (conv, pool, fc domains).
// Optional statistics counters and clr_stats are built only when CG_STATS_EN is defined.
module clock_enable_controller
    import cg_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_conv,
    input  logic             req_pool,
    input  logic             req_fc,
    input  logic             busy_conv,
    input  logic             busy_pool,
    input  logic             busy_fc,
    input  logic             force_on,
`ifdef CG_STATS_EN
    input  logic             clr_stats,
    output logic [CNT_W-1:0] cyc_conv,
    output logic [CNT_W-1:0] cyc_pool,
    output logic [CNT_W-1:0] cyc_fc,
`endif
    output logic             en_conv,
    output logic             en_pool,
    output logic             en_fc,
    output logic             rdy_conv,
    output logic             rdy_pool,
    output logic             rdy_fc,
    output logic             all_idle,
    output logic             proto_err
);

    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15 || IDLE_CYCLES < 1 || IDLE_CYCLES > 255 || CNT_W < 1)
    begin : g_param_check
        $error("clock_enable_controller: parameter out of legal range");
    end

    logic [NUM_CG_DOMAINS-1:0] w_req;
    logic [NUM_CG_DOMAINS-1:0] w_busy;
    logic [NUM_CG_DOMAINS-1:0] w_en;
    logic [NUM_CG_DOMAINS-1:0] w_rdy;
    logic [NUM_CG_DOMAINS-1:0] w_err;
    logic [NUM_CG_DOMAINS-1:0] w_off;
    logic [1:0]                w_state [NUM_CG_DOMAINS];
`ifdef CG_STATS_EN
    logic [CNT_W-1:0]          w_cyc   [NUM_CG_DOMAINS];
`endif
    logic                      r_live;

    assign w_req[CG_CONV]  = req_conv;
    assign w_req[CG_POOL]  = req_pool;
    assign w_req[CG_FC]    = req_fc;
    assign w_busy[CG_CONV] = busy_conv;
    assign w_busy[CG_POOL] = busy_pool;
    assign w_busy[CG_FC]   = busy_fc;

    for (genvar g = 0; g < NUM_CG_DOMAINS; g++) begin : g_dom
        cg_domain_fsm #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES)
`ifdef CG_STATS_EN
            ,
            .CNT_W       (CNT_W)
`endif
        ) u_fsm (
            .i_clk       (clk),
            .i_rst       (reset),
            .i_req       (w_req[g]),
            .i_busy      (w_busy[g]),
            .i_force     (force_on),
`ifdef CG_STATS_EN
            .i_clr_stats (clr_stats),
            .o_cyc       (w_cyc[g]),
`endif
            .o_en        (w_en[g]),
            .o_rdy       (w_rdy[g]),
            .o_err       (w_err[g]),
            .o_state     (w_state[g])
        );

        assign w_off[g] = (w_state[g] == CG_OFF);
    end

    // Low through reset and until the first edge after release, so all_idle reads 0 in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign en_conv   = w_en[CG_CONV];
    assign en_pool   = w_en[CG_POOL];
    assign en_fc     = w_en[CG_FC];
    assign rdy_conv  = w_rdy[CG_CONV];
    assign rdy_pool  = w_rdy[CG_POOL];
    assign rdy_fc    = w_rdy[CG_FC];
    assign all_idle  = r_live & (&w_off);
    assign proto_err = |w_err;

`ifdef CG_STATS_EN
    assign cyc_conv = w_cyc[CG_CONV];
    assign cyc_pool = w_cyc[CG_POOL];
    assign cyc_fc   = w_cyc[CG_FC];
`endif

endmodule

// File: tb/tb_clock_enable_controller.sv
// Directed bench for clock_enable_controller; the stats section is built with CG_STATS_EN.
module tb_clock_enable_controller;

`ifdef CG_STATS_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 32;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_conv = 1'b0, req_pool = 1'b0, req_fc = 1'b0;
    logic busy_conv = 1'b0, busy_pool = 1'b0, busy_fc = 1'b0;
    logic force_on = 1'b0;
    logic en_conv, en_pool, en_fc;
    logic rdy_conv, rdy_pool, rdy_fc;
    logic all_idle, proto_err;
`ifdef CG_STATS_EN
    logic clr_stats = 1'b0;
    logic [TB_CNT_W-1:0] cyc_conv, cyc_pool, cyc_fc;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic held;

    always #5 clk = ~clk;

    clock_enable_controller #(
        .WAKE_CYCLES (2),
        .IDLE_CYCLES (8),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_conv  (req_conv),
        .req_pool  (req_pool),
        .req_fc    (req_fc),
        .busy_conv (busy_conv),
        .busy_pool (busy_pool),
        .busy_fc   (busy_fc),
        .force_on  (force_on),
`ifdef CG_STATS_EN
        .clr_stats (clr_stats),
        .cyc_conv  (cyc_conv),
        .cyc_pool  (cyc_pool),
        .cyc_fc    (cyc_fc),
`endif
        .en_conv   (en_conv),
        .en_pool   (en_pool),
        .en_fc     (en_fc),
        .rdy_conv  (rdy_conv),
        .rdy_pool  (rdy_pool),
        .rdy_fc    (rdy_fc),
        .all_idle  (all_idle),
        .proto_err (proto_err)
    );

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1;
        step();
        chk("rst_en_conv", en_conv, 1'b0);
        chk("rst_rdy_conv", rdy_conv, 1'b0);
        chk("rst_all_idle", all_idle, 1'b0);
        chk("rst_proto_err", proto_err, 1'b0);
`ifdef CG_STATS_EN
        chk_cnt("rst_cyc_conv", 32'(cyc_conv), 32'd0);
`endif
        reset = 1'b0;
        step();
        chk("post_rst_all_idle", all_idle, 1'b1);

        // Basic wake and idle: one-cycle request pulse
        req_conv = 1'b1;
        step();
        chk("basic_en_e1", en_conv, 1'b1);
        chk("basic_rdy_e1", rdy_conv, 1'b0);
        chk("basic_all_idle_e1", all_idle, 1'b0);
        req_conv = 1'b0;
        step();
        chk("basic_rdy_e2", rdy_conv, 1'b0);
        step();
        chk("basic_rdy_e3", rdy_conv, 1'b1);
        repeat (7) step();
        chk("basic_en_e10", en_conv, 1'b1);
        chk("basic_rdy_e10", rdy_conv, 1'b1);
        step();
        chk("basic_en_e11", en_conv, 1'b0);
        chk("basic_rdy_e11", rdy_conv, 1'b0);
        chk("basic_en_pool", en_pool, 1'b0);
        chk("basic_en_fc", en_fc, 1'b0);
        chk("basic_all_idle_end", all_idle, 1'b1);

        // Busy holds ON
        req_pool = 1'b1;
        repeat (3) step();
        chk("busy_rdy_pool", rdy_pool, 1'b1);
        req_pool  = 1'b0;
        busy_pool = 1'b1;
        held = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (en_pool !== 1'b1) held = 1'b0;
        end
        chk("busy_en_held", held, 1'b1);
        busy_pool = 1'b0;
        repeat (7) step();
        chk("busy_en_idle7", en_pool, 1'b1);
        step();
        chk("busy_en_idle8", en_pool, 1'b0);
        chk("busy_no_err", proto_err, 1'b0);

        // Idle-expiry race: re-request on the last idle cycle
        req_fc = 1'b1;
        repeat (3) step();
        chk("race_rdy_fc", rdy_fc, 1'b1);
        req_fc = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (en_fc !== 1'b1 || rdy_fc !== 1'b1) held = 1'b0;
        end
        req_fc = 1'b1;
        step();
        chk("race_en_fc", en_fc, 1'b1);
        chk("race_rdy_fc_kept", rdy_fc, 1'b1);
        req_fc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (en_fc !== 1'b1 || rdy_fc !== 1'b1) held = 1'b0;
        end
        chk("race_no_glitch", held, 1'b1);
        step();
        chk("race_en_fc_off", en_fc, 1'b0);

        // Force from all-OFF
        chk("force_pre_idle", all_idle, 1'b1);
        force_on = 1'b1;
        step();
        chk("force_en_conv_e1", en_conv, 1'b1);
        chk("force_en_pool_e1", en_pool, 1'b1);
        chk("force_en_fc_e1", en_fc, 1'b1);
        step();
        chk("force_rdy_fc_e2", rdy_fc, 1'b0);
        step();
        chk("force_rdy_conv_e3", rdy_conv, 1'b1);
        chk("force_rdy_pool_e3", rdy_pool, 1'b1);
        chk("force_rdy_fc_e3", rdy_fc, 1'b1);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({rdy_conv, rdy_pool, rdy_fc} !== 3'b111) held = 1'b0;
        end
        chk("force_held", held, 1'b1);
        force_on = 1'b0;
        repeat (7) step();
        chk("force_rel_en7", en_pool, 1'b1);
        step();
        chk("force_rel_idle8", all_idle, 1'b1);
        chk("force_no_err", proto_err, 1'b0);

        // Busy while OFF flags a protocol error that stays set
        busy_fc = 1'b1;
        step();
        chk("err_set", proto_err, 1'b1);
        busy_fc = 1'b0;
        step();
        chk("err_sticky", proto_err, 1'b1);
        repeat (12) step();
        chk("err_sticky_idle", proto_err, 1'b1);
        chk("err_all_idle", all_idle, 1'b1);

        // Reset mid-WAKE
        req_conv = 1'b1;
        step();
        chk("rstw_en_e1", en_conv, 1'b1);
        step();
        reset = 1'b1;
        #1;
        chk("rstw_en_conv", en_conv, 1'b0);
        chk("rstw_rdy_conv", rdy_conv, 1'b0);
        chk("rstw_proto_err", proto_err, 1'b0);
        chk("rstw_all_idle", all_idle, 1'b0);
        req_conv = 1'b0;
        step();
        chk("rstw_en_held", en_conv, 1'b0);
        reset = 1'b0;
        step();
        chk("rstw_all_idle_rel", all_idle, 1'b1);
        req_conv = 1'b1;
        step();
        chk("rstw_re_en_e1", en_conv, 1'b1);
        chk("rstw_re_rdy_e1", rdy_conv, 1'b0);
        req_conv = 1'b0;
        step();
        chk("rstw_re_rdy_e2", rdy_conv, 1'b0);
        step();
        chk("rstw_re_rdy_e3", rdy_conv, 1'b1);
        repeat (8) step();
        chk("rstw_re_off", en_conv, 1'b0);

`ifdef CG_STATS_EN
        // Stats: saturation and clear priority
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_cnt("stats_rst", 32'(cyc_conv), 32'd0);
        req_conv = 1'b1;
        repeat (3) step();
        req_conv  = 1'b0;
        busy_conv = 1'b1;
        repeat (20) step();
        chk_cnt("stats_sat", 32'(cyc_conv), 32'd15);
        chk_cnt("stats_pool_zero", 32'(cyc_pool), 32'd0);
        clr_stats = 1'b1;
        step();
        chk_cnt("stats_clr", 32'(cyc_conv), 32'd0);
        clr_stats = 1'b0;
        step();
        chk_cnt("stats_after_clr", 32'(cyc_conv), 32'd1);
        busy_conv = 1'b0;
        repeat (10) step();
        chk("stats_all_idle", all_idle, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
